// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // RV32I canonical NOP (addi x0, x0, 0), substituted on a misaligned fetch.
    localparam logic [31:0] NOP = 32'h00000013;

endpackage

// File: rtl/ifetch.sv
// Single-outstanding instruction fetch FSM: IDLE -> REQ -> HOLD, with DRAIN to swallow a flushed response.
// Optional misaligned-PC trap when IFETCH_MISALIGN_CHECK_EN is defined; otherwise addresses are word-aligned.
module ifetch
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        pc_advance,
    output logic        fetch_fault
);

    state_t state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_addr <= '0;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            case (state)
                IDLE: begin
`ifdef IFETCH_MISALIGN_CHECK_EN
                    if (pc_in[1:0] != 2'b00) begin
                        instr    <= NOP;
                        instr_pc <= pc_in;
                        state    <= HOLD;
                    end else
`endif
                    begin
                        mem_addr <= {pc_in[31:2], 2'b00};
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!flush) begin
                            instr    <= mem_rdata;
                            instr_pc <= mem_addr;
                            state    <= HOLD;
                        end else begin
                            state    <= IDLE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                HOLD: begin
                    if (flush || instr_ready) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    // The outstanding response must still be consumed; its data is dropped.
                    if (mem_ack) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic fault_q;

    // Refreshed on every fetch start, so it always describes the word held in HOLD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else if (state == IDLE) begin
            fault_q <= (pc_in[1:0] != 2'b00);
        end
    end

    assign fetch_fault = fault_q;
`else
    logic unused_pc_lsbs;

    assign unused_pc_lsbs = ^pc_in[1:0];
    assign fetch_fault    = 1'b0;
`endif

    assign mem_req     = (state == REQ) || (state == DRAIN);
    assign instr_valid = (state == HOLD);
    assign pc_advance  = instr_valid && instr_ready && !flush;

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_ifetch;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_advance;
    logic        fetch_fault;

    ifetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_advance  (pc_advance),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic fl, input logic ak,
                         input logic [31:0] rd, input logic rdy);
        rst_n       = r;
        pc_in       = pc;
        flush       = fl;
        mem_ack     = ak;
        mem_rdata   = rd;
        instr_ready = rdy;
    endtask

    typedef struct {
        logic        r;
        logic [31:0] pc;
        logic        fl;
        logic        ak;
        logic [31:0] rd;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] ins;
        logic [31:0] ipc;
        logic        adv;
    } vec_t;

    function automatic vec_t mk(logic r, logic [31:0] pc, logic fl, logic ak, logic [31:0] rd,
                                logic rdy, logic req, logic [31:0] addr, logic vld,
                                logic [31:0] ins, logic [31:0] ipc, logic adv);
        vec_t v;
        v.r = r; v.pc = pc; v.fl = fl; v.ak = ak; v.rd = rd; v.rdy = rdy;
        v.req = req; v.addr = addr; v.vld = vld; v.ins = ins; v.ipc = ipc; v.adv = adv;
        return v;
    endfunction

    vec_t vecs[16];

    // Reference model: tracks what is outstanding and what is held, not FSM states.
    logic        m_pending, m_discard, m_valid, m_fault;
    logic [31:0] m_addr, m_instr, m_ipc;

    task automatic model_reset();
        m_pending = 1'b0; m_discard = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
        m_addr = '0; m_instr = '0; m_ipc = '0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (m_valid) begin
            if (flush || instr_ready) m_valid = 1'b0;
        end else if (m_pending) begin
            if (mem_ack) begin
                if (!m_discard && !flush) begin
                    m_valid = 1'b1;
                    m_instr = mem_rdata;
                    m_ipc   = m_addr;
                    m_fault = 1'b0;
                end
                m_pending = 1'b0;
                m_discard = 1'b0;
            end else if (flush) begin
                m_discard = 1'b1;
            end
        end else begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (pc_in % 4 != 0) begin
                m_valid = 1'b1;
                m_instr = NOP;
                m_ipc   = pc_in;
                m_fault = 1'b1;
            end else begin
                m_addr    = pc_in;
                m_pending = 1'b1;
            end
`else
            m_addr    = pc_in - (pc_in % 4);
            m_pending = 1'b1;
`endif
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = mk(1, 32'h100, 0, 0, 32'h0,        0, 0, 32'h0,   0, 32'h0,        32'h0,   0);
        vecs[1]  = mk(1, 32'h100, 0, 1, 32'h00500093, 0, 1, 32'h100, 0, 32'h0,        32'h0,   0);
        vecs[2]  = mk(1, 32'h100, 0, 0, 32'h0,        1, 0, 32'h100, 1, 32'h00500093, 32'h100, 1);
        vecs[3]  = mk(1, 32'h200, 0, 0, 32'h0,        0, 0, 32'h100, 0, 32'h00500093, 32'h100, 0);
        vecs[4]  = mk(1, 32'h200, 0, 0, 32'h0,        0, 1, 32'h200, 0, 32'h00500093, 32'h100, 0);
        vecs[5]  = mk(1, 32'h200, 0, 0, 32'h0,        0, 1, 32'h200, 0, 32'h00500093, 32'h100, 0);
        vecs[6]  = mk(1, 32'h200, 0, 0, 32'h0,        0, 1, 32'h200, 0, 32'h00500093, 32'h100, 0);
        vecs[7]  = mk(1, 32'h200, 0, 1, 32'h11111111, 0, 1, 32'h200, 0, 32'h00500093, 32'h100, 0);
        vecs[8]  = mk(1, 32'h200, 0, 0, 32'h0,        1, 0, 32'h200, 1, 32'h11111111, 32'h200, 1);
        vecs[9]  = mk(1, 32'h300, 0, 0, 32'h0,        0, 0, 32'h200, 0, 32'h11111111, 32'h200, 0);
        vecs[10] = mk(1, 32'h300, 1, 0, 32'h0,        0, 1, 32'h300, 0, 32'h11111111, 32'h200, 0);
        vecs[11] = mk(1, 32'h400, 0, 0, 32'h0,        0, 1, 32'h300, 0, 32'h11111111, 32'h200, 0);
        vecs[12] = mk(1, 32'h400, 0, 1, 32'hDEADBEEF, 0, 1, 32'h300, 0, 32'h11111111, 32'h200, 0);
        vecs[13] = mk(1, 32'h400, 0, 0, 32'h0,        0, 0, 32'h300, 0, 32'h11111111, 32'h200, 0);
        vecs[14] = mk(1, 32'h400, 0, 1, 32'h22222222, 0, 1, 32'h400, 0, 32'h11111111, 32'h200, 0);
        vecs[15] = mk(1, 32'h400, 0, 0, 32'h0,        0, 0, 32'h400, 1, 32'h22222222, 32'h400, 0);

        drive(0, 32'h0, 0, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].r, vecs[i].pc, vecs[i].fl, vecs[i].ak, vecs[i].rd, vecs[i].rdy);
            #1;
            check($sformatf("vec%0d.mem_req", i),     32'(mem_req),     32'(vecs[i].req));
            check($sformatf("vec%0d.mem_addr", i),    mem_addr,         vecs[i].addr);
            check($sformatf("vec%0d.instr_valid", i), 32'(instr_valid), 32'(vecs[i].vld));
            check($sformatf("vec%0d.instr", i),       instr,            vecs[i].ins);
            check($sformatf("vec%0d.instr_pc", i),    instr_pc,         vecs[i].ipc);
            check($sformatf("vec%0d.pc_advance", i),  32'(pc_advance),  32'(vecs[i].adv));
            check($sformatf("vec%0d.fetch_fault", i), 32'(fetch_fault), 32'h0);
            @(negedge clk);
        end

        // HOLD stall: four more cycles with instr_ready low (five in total).
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h500, 0, 0, 32'h0, 0);
            #1;
            check($sformatf("stall%0d.instr_valid", i), 32'(instr_valid), 32'h1);
            check($sformatf("stall%0d.instr", i),       instr,            32'h22222222);
            check($sformatf("stall%0d.pc_advance", i),  32'(pc_advance),  32'h0);
            @(negedge clk);
        end
        drive(1, 32'h500, 1, 0, 32'h0, 1);
        #1;
        check("flush_ready.pc_advance", 32'(pc_advance), 32'h0);
        @(negedge clk);
        drive(1, 32'h500, 0, 0, 32'h0, 0);
        #1;
        check("after_flush.instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);

        // Reset while a request is outstanding, then an orphan ack.
        drive(0, 32'h500, 0, 0, 32'h0, 0);
        #1;
        check("pre_reset.mem_req",  32'(mem_req), 32'h1);
        check("pre_reset.mem_addr", mem_addr,      32'h500);
        @(negedge clk);
        drive(1, 32'h600, 0, 1, 32'hBAD0BAD0, 0);
        #1;
        check("post_reset.mem_req",     32'(mem_req),     32'h0);
        check("post_reset.mem_addr",    mem_addr,         32'h0);
        check("post_reset.instr",       instr,            32'h0);
        check("post_reset.instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        drive(1, 32'h600, 0, 0, 32'h0, 0);
        #1;
        check("late_ack.instr_valid", 32'(instr_valid), 32'h0);
        check("late_ack.mem_req",     32'(mem_req),     32'h1);
        check("late_ack.mem_addr",    mem_addr,         32'h600);
        @(negedge clk);
        drive(1, 32'h600, 0, 1, 32'h33333333, 0);
        #1;
        check("refetch.instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
        drive(1, 32'h600, 0, 0, 32'h0, 1);
        #1;
        check("refetch.instr",      instr,           32'h33333333);
        check("refetch.instr_pc",   instr_pc,        32'h600);
        check("refetch.pc_advance", 32'(pc_advance), 32'h1);
        @(negedge clk);

        // Misaligned PC.
        drive(1, 32'h102, 0, 0, 32'h0, 0);
        #1;
        check("misalign_idle.instr_valid", 32'(instr_valid), 32'h0);
        @(negedge clk);
`ifdef IFETCH_MISALIGN_CHECK_EN
        drive(1, 32'h102, 0, 0, 32'h0, 1);
        #1;
        check("misalign.mem_req",     32'(mem_req),     32'h0);
        check("misalign.instr_valid", 32'(instr_valid), 32'h1);
        check("misalign.instr",       instr,            NOP);
        check("misalign.instr_pc",    instr_pc,         32'h102);
        check("misalign.fetch_fault", 32'(fetch_fault), 32'h1);
        check("misalign.pc_advance",  32'(pc_advance),  32'h1);
        @(negedge clk);
`else
        drive(1, 32'h102, 0, 1, 32'h44444444, 0);
        #1;
        check("misalign.mem_req",  32'(mem_req), 32'h1);
        check("misalign.mem_addr", mem_addr,     32'h100);
        @(negedge clk);
        drive(1, 32'h102, 0, 0, 32'h0, 1);
        #1;
        check("misalign.instr_pc",    instr_pc,         32'h100);
        check("misalign.fetch_fault", 32'(fetch_fault), 32'h0);
        check("misalign.pc_advance",  32'(pc_advance),  32'h1);
        @(negedge clk);
`endif

        // Randomized traffic against the reference model.
        drive(0, 32'h0, 0, 0, 32'h0, 0);
        model_step();
        @(negedge clk);
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 2) == 0),
                  $urandom,
                  1'($urandom_range(0, 1)));
            #1;
            check($sformatf("rnd%0d.mem_req", i),     32'(mem_req),     32'(m_pending));
            check($sformatf("rnd%0d.instr_valid", i), 32'(instr_valid), 32'(m_valid));
            check($sformatf("rnd%0d.pc_advance", i),  32'(pc_advance),
                  32'(m_valid && instr_ready && !flush));
            if (m_pending) begin
                check($sformatf("rnd%0d.mem_addr", i), mem_addr, m_addr);
            end
            if (m_valid) begin
                check($sformatf("rnd%0d.instr", i),       instr,            m_instr);
                check($sformatf("rnd%0d.instr_pc", i),    instr_pc,         m_ipc);
                check($sformatf("rnd%0d.fetch_fault", i), 32'(fetch_fault), 32'(m_fault));
            end
            model_step();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset, with ports in this order:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- pc_in  input  32  current PC from the pc stage
- flush  input  1  redirect; discard any in-flight or held fetch
- mem_req  output  1  instruction memory request, held until mem_ack
- mem_addr  output  32  request address, stable while mem_req=1
- mem_ack  input  1  memory response valid, one-cycle pulse
- mem_rdata  input  32  instruction word, valid when mem_ack=1
- instr  output  32  fetched instruction to decode
- instr_pc  output  32  address of instr
- instr_valid  output  1  instr/instr_pc valid
- instr_ready  input  1  decode accepts instr
- pc_advance  output  1  one-cycle pulse permitting the pc stage to update
- fetch_fault  output  1  misaligned-fetch flag, valid with instr_valid

Function
REQ-002 The FSM SHALL have four states: IDLE, REQ, HOLD, DRAIN.
REQ-003 IDLE: latch pc_in into mem_addr and enter REQ the next cycle; flush in IDLE has no effect.
REQ-004 REQ: mem_req=1 with mem_addr stable.
- mem_ack without flush: latch mem_rdata into instr and mem_addr into instr_pc, then enter HOLD.
- flush without mem_ack: enter DRAIN.
- flush with mem_ack: discard mem_rdata and enter IDLE.
REQ-005 HOLD: instr_valid=1; instr and instr_pc stable.
- instr_ready=1 and flush=0: pc_advance=1 in that same cycle, then enter IDLE.
- flush=1 (takes priority over instr_ready): instr_valid drops the next cycle, pc_advance=0, enter IDLE.
REQ-006 DRAIN: mem_req stays 1 with the old mem_addr until mem_ack; that response is discarded and the FSM enters IDLE; further flushes in DRAIN are ignored.
REQ-007 pc_advance SHALL be asserted only in the cycle of an instr_valid & instr_ready handshake with flush=0, for exactly one cycle.
REQ-008 Minimum latency from IDLE to instr_valid SHALL be 2 cycles (mem_ack in the first REQ cycle); the no-stall throughput is one instruction per 3 cycles.
REQ-009 mem_req SHALL never be asserted in IDLE or HOLD; there is at most one outstanding request.
REQ-010 mem_ack outside REQ or DRAIN SHALL be ignored.

Reset
REQ-011 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear every register: mem_req=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, pc_advance=0, fetch_fault=0.
REQ-012 Reset mid-request SHALL drop mem_req immediately; a late mem_ack after reset SHALL be ignored.

Configuration
REQ-013 With IFETCH_MISALIGN_CHECK_EN defined:
- IDLE with pc_in[1:0]!=0 issues no memory request.
- The FSM enters HOLD directly with instr=32'h00000013 (NOP), instr_pc=pc_in, and fetch_fault=1.
- The handshake proceeds as in REQ-005.
REQ-014 Without IFETCH_MISALIGN_CHECK_EN: mem_addr[1:0] is forced to 0, and fetch_fault is tied to 0 but the port is kept.

Structure
REQ-015 The package ifetch_pkg SHALL hold the state enum (IDLE, REQ, HOLD, DRAIN) and the NOP constant 32'h00000013.
REQ-016 No sub-module is needed; the block is a single module with one FSM and its datapath registers.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then pc_in=0x100 and mem_ack on the first REQ cycle with rdata=0x00500093 -> instr_valid at cycle 2, instr=0x00500093, instr_pc=0x100, and pc_advance pulses once when instr_ready=1.
- mem_ack delayed 3 cycles -> mem_req and mem_addr held stable for 4 cycles and instr_valid=0 throughout.
- flush in REQ without ack, then ack 2 cycles later with rdata=0xDEADBEEF -> DRAIN, data discarded, instr_valid never rises, and the next fetch uses the new pc_in.
- HOLD with instr_ready=0 for 5 cycles -> instr is stable and pc_advance=0; then flush and instr_ready together -> no pc_advance and instr_valid drops.
- rst_n=0 during REQ -> mem_req=0 the next cycle and a following mem_ack is ignored.
- With the macro defined, pc_in=0x102 -> no mem_req, instr=0x00000013, fetch_fault=1; without the macro, mem_addr=0x100.
